// File: rtl/sdram_responder_if.sv
`default_nettype none
// ============================================================================
// sdram_responder_if : SDR SDRAM command/data bus between controller and device
// Rev 1.0
// ============================================================================
interface sdram_responder_if;
  logic        SDRAM_nCS;
  logic        SDRAM_nRAS;
  logic        SDRAM_nCAS;
  logic        SDRAM_nWE;
  logic        SDRAM_CKE;
  logic [1:0]  SDRAM_BA;
  logic [12:0] SDRAM_A;
  logic        SDRAM_DQML;
  logic        SDRAM_DQMH;
  logic [15:0] SDRAM_DQ_I;
  logic [15:0] SDRAM_DQ_O;
  logic [1:0]  SDRAM_DQ_OE;

  modport master (
    output SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE, SDRAM_CKE,
           SDRAM_BA, SDRAM_A, SDRAM_DQML, SDRAM_DQMH, SDRAM_DQ_I,
    input  SDRAM_DQ_O, SDRAM_DQ_OE
  );

  modport slave (
    input  SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE, SDRAM_CKE,
           SDRAM_BA, SDRAM_A, SDRAM_DQML, SDRAM_DQMH, SDRAM_DQ_I,
    output SDRAM_DQ_O, SDRAM_DQ_OE
  );
endinterface
`default_nettype wire

// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
// sdram_responder : device-side SDR SDRAM model with init/bank/timing checks
// Rev 1.0
// ============================================================================
module sdram_responder #(
  parameter int ROW_W = 4,
  parameter int COL_W = 5,
  parameter int TRCD  = 2,
  parameter int TRP   = 2,
  parameter int TRFC  = 7
) (
  input  wire logic        clk,
  input  wire logic        init_n,
  sdram_responder_if.slave bus,
  output logic             initialized,
  output logic [12:0]      mode_reg,
  output logic [15:0]      rfsh_count,
  output logic             err_seq,
  output logic             err_bank,
  output logic             err_timing,
  output logic             err_mode
);

  localparam int AW    = 2 + ROW_W + COL_W;
  localparam int DEPTH = 1 << AW;
  localparam int TW    = 8;
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] TRCD_LD = TW'((TRCD > 0) ? TRCD - 1 : 0);
  localparam logic [TW-1:0] TRP_LD  = TW'((TRP  > 0) ? TRP  - 1 : 0);
  localparam logic [TW-1:0] TRFC_LD = TW'((TRFC > 0) ? TRFC - 1 : 0);

  typedef enum logic [2:0] {
    ST_WAIT_PRE  = 3'd0,
    ST_WAIT_RF1  = 3'd1,
    ST_WAIT_RF2  = 3'd2,
    ST_WAIT_MODE = 3'd3,
    ST_READY     = 3'd4
  } init_state_e;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  init_state_e            state_q, state_d;
  logic [12:0]            mode_q, mode_d;
  logic                   cl3_q, cl3_d;
  logic [15:0]            rfsh_q, rfsh_d;
  logic                   err_seq_q, err_seq_d;
  logic                   err_bank_q, err_bank_d;
  logic                   err_timing_q, err_timing_d;
  logic                   err_mode_q, err_mode_d;
  logic [3:0]             open_q, open_d;
  logic [3:0][ROW_W-1:0]  row_q, row_d;
  logic [3:0][TW-1:0]     trcd_q, trcd_d;
  logic [TW-1:0]          trp_q, trp_d;
  logic [TW-1:0]          trfc_q, trfc_d;
  logic [1:0]             pipe1_oe_q, pipe1_oe_d;
  logic [15:0]            pipe1_data_q, pipe1_data_d;
  logic [1:0]             pipe2_oe_q, pipe2_oe_d;
  logic [15:0]            pipe2_data_q, pipe2_data_d;
  logic [1:0]             dq_oe_q, dq_oe_d;
  logic [15:0]            dq_o_q, dq_o_d;

  cmd_e                   cmd;
  logic                   is_cmd;
  logic                   seq_advance;
  logic [1:0]             ba;
  logic [1:0]             dqm;
  logic                   a10;
  logic [ROW_W-1:0]       row_sel;
  logic [AW-1:0]          addr;
  logic [15:0]            rd_word;
  logic [1:0]             out_oe;
  logic [15:0]            out_data;

  // Deselected or clock-disabled cycles look exactly like NOP downstream
  assign cmd = (bus.SDRAM_CKE && !bus.SDRAM_nCS)
             ? cmd_e'({bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE})
             : CMD_NOP;
  assign is_cmd  = (cmd != CMD_NOP) && (cmd != CMD_BST);
  assign ba      = bus.SDRAM_BA;
  assign dqm     = {bus.SDRAM_DQMH, bus.SDRAM_DQML};
  assign a10     = bus.SDRAM_A[10];
  assign row_sel = open_q[ba] ? row_q[ba] : '0;
  assign addr    = {ba, row_sel, bus.SDRAM_A[COL_W-1:0]};

  for (genvar gb = 0; gb < 2; gb++) begin : g_byte_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (cmd == CMD_WR && !dqm[gb]) begin
        lane_mem[addr] <= bus.SDRAM_DQ_I[gb*8 +: 8];
      end
    end

    assign rd_word[gb*8 +: 8] = lane_mem[addr];
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cl3_d        = cl3_q;
    rfsh_d       = rfsh_q;
    err_seq_d    = err_seq_q;
    err_bank_d   = err_bank_q;
    err_timing_d = err_timing_q;
    err_mode_d   = err_mode_q;
    open_d       = open_q;
    row_d        = row_q;
    seq_advance  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - T_ONE : '0;
    end
    trp_d  = (trp_q  != '0) ? trp_q  - T_ONE : '0;
    trfc_d = (trfc_q != '0) ? trfc_q - T_ONE : '0;

    case (state_q)
      ST_WAIT_PRE:  seq_advance = (cmd == CMD_PRE) && a10;
      ST_WAIT_RF1,
      ST_WAIT_RF2:  seq_advance = (cmd == CMD_REF);
      ST_WAIT_MODE: seq_advance = (cmd == CMD_LMR);
      default:      seq_advance = 1'b0;
    endcase
    if (seq_advance) begin
      state_d = init_state_e'(state_q + 3'd1);
    end
    if (state_q != ST_READY && is_cmd && !seq_advance) begin
      err_seq_d = 1'b1;
    end

    if (is_cmd && trfc_q != '0) begin
      err_timing_d = 1'b1;
    end

    // Commands always take effect; violations only raise sticky flags
    case (cmd)
      CMD_ACT: begin
        if (open_q[ba])     err_bank_d   = 1'b1;
        if (trp_q != '0)    err_timing_d = 1'b1;
        open_d[ba] = 1'b1;
        row_d[ba]  = bus.SDRAM_A[ROW_W-1:0];
        trcd_d[ba] = TRCD_LD;
      end
      CMD_RD, CMD_WR: begin
        if (!open_q[ba])             err_bank_d   = 1'b1;
        else if (trcd_q[ba] != '0)   err_timing_d = 1'b1;
      end
      CMD_PRE: begin
        if (a10) open_d     = '0;
        else     open_d[ba] = 1'b0;
        trp_d = TRP_LD;
      end
      CMD_REF: begin
        if (|open_q)        err_bank_d   = 1'b1;
        if (trp_q != '0)    err_timing_d = 1'b1;
        rfsh_d = rfsh_q + 16'd1;
        trfc_d = TRFC_LD;
      end
      CMD_LMR: begin
        mode_d = bus.SDRAM_A;
        cl3_d  = (bus.SDRAM_A[6:4] == 3'd3);
        if (bus.SDRAM_A[2:0] != 3'd0 ||
            (bus.SDRAM_A[6:4] != 3'd2 && bus.SDRAM_A[6:4] != 3'd3)) begin
          err_mode_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Read pipeline: stage 1 feeds the output for CL2, stage 2 for CL3
    pipe1_oe_d   = 2'b00;
    pipe1_data_d = '0;
    if (cmd == CMD_RD) begin
      pipe1_oe_d   = ~dqm;
      pipe1_data_d = rd_word;
    end
    pipe2_oe_d   = pipe1_oe_q;
    pipe2_data_d = pipe1_data_q;
    out_oe       = cl3_q ? pipe2_oe_q   : pipe1_oe_q;
    out_data     = cl3_q ? pipe2_data_q : pipe1_data_q;
    dq_oe_d      = out_oe;
    dq_o_d       = (out_oe != 2'b00) ? out_data : '0;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q      <= ST_WAIT_PRE;
      mode_q       <= '0;
      cl3_q        <= 1'b0;
      rfsh_q       <= '0;
      err_seq_q    <= 1'b0;
      err_bank_q   <= 1'b0;
      err_timing_q <= 1'b0;
      err_mode_q   <= 1'b0;
      open_q       <= '0;
      row_q        <= '0;
      trcd_q       <= '0;
      trp_q        <= '0;
      trfc_q       <= '0;
      pipe1_oe_q   <= '0;
      pipe1_data_q <= '0;
      pipe2_oe_q   <= '0;
      pipe2_data_q <= '0;
      dq_oe_q      <= '0;
      dq_o_q       <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cl3_q        <= cl3_d;
      rfsh_q       <= rfsh_d;
      err_seq_q    <= err_seq_d;
      err_bank_q   <= err_bank_d;
      err_timing_q <= err_timing_d;
      err_mode_q   <= err_mode_d;
      open_q       <= open_d;
      row_q        <= row_d;
      trcd_q       <= trcd_d;
      trp_q        <= trp_d;
      trfc_q       <= trfc_d;
      pipe1_oe_q   <= pipe1_oe_d;
      pipe1_data_q <= pipe1_data_d;
      pipe2_oe_q   <= pipe2_oe_d;
      pipe2_data_q <= pipe2_data_d;
      dq_oe_q      <= dq_oe_d;
      dq_o_q       <= dq_o_d;
    end
  end

  assign bus.SDRAM_DQ_O  = dq_o_q;
  assign bus.SDRAM_DQ_OE = dq_oe_q;
  assign initialized     = (state_q == ST_READY);
  assign mode_reg        = mode_q;
  assign rfsh_count      = rfsh_q;
  assign err_seq         = err_seq_q;
  assign err_bank        = err_bank_q;
  assign err_timing      = err_timing_q;
  assign err_mode        = err_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`default_nettype none
// ============================================================================
// tb_sdram_responder : directed + randomized bench with a behavioural memory model
// Rev 1.0
// ============================================================================
module tb_sdram_responder;
  localparam int ROW_W = 4;
  localparam int COL_W = 5;
  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] RD  = 3'b101;
  localparam logic [2:0] WR  = 3'b100;
  localparam logic [2:0] ACT = 3'b011;
  localparam logic [2:0] PRE = 3'b010;
  localparam logic [2:0] REF = 3'b001;
  localparam logic [2:0] LMR = 3'b000;

  logic clk = 1'b0;
  logic init_n = 1'b0;
  always #5 clk = ~clk;

  sdram_responder_if bus ();
  logic        initialized;
  logic [12:0] mode_reg;
  logic [15:0] rfsh_count;
  logic        err_seq, err_bank, err_timing, err_mode;

  sdram_responder #(.ROW_W(ROW_W), .COL_W(COL_W), .TRCD(2), .TRP(2), .TRFC(7)) dut (
    .clk(clk), .init_n(init_n), .bus(bus),
    .initialized(initialized), .mode_reg(mode_reg), .rfsh_count(rfsh_count),
    .err_seq(err_seq), .err_bank(err_bank), .err_timing(err_timing), .err_mode(err_mode)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cl_model = 2;
  logic [15:0] model_mem [int];
  logic [1:0]  exp_oe [int];
  logic [15:0] exp_dq [int];
  bit          model_open [4];
  int          model_row [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, 32'({err_seq, err_bank, err_timing, err_mode}), 32'(exp));
  endtask

  function automatic int idx_of(input int b, input logic [12:0] a);
    int row;
    row = model_open[b] ? model_row[b] : 0;
    return b * (1 << (ROW_W + COL_W)) + row * (1 << COL_W) + int'(a[COL_W-1:0]);
  endfunction

  // One clock; every cycle the data bus is compared against the model's schedule
  task automatic tick();
    logic [1:0]  eo;
    logic [15:0] ed;
    @(posedge clk);
    cyc++;
    #1;
    eo = exp_oe.exists(cyc) ? exp_oe[cyc] : 2'b00;
    ed = exp_dq.exists(cyc) ? exp_dq[cyc] : 16'h0000;
    check("dq_oe", 32'(bus.SDRAM_DQ_OE), 32'(eo));
    check("dq_o",  32'(bus.SDRAM_DQ_O),  32'(ed));
    {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = NOP;
    bus.SDRAM_DQ_I = 16'h0;
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [1:0] dqm, input logic [15:0] dq);
    int idx;
    logic [15:0] w;
    {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = c;
    bus.SDRAM_BA   = ba;
    bus.SDRAM_A    = a;
    bus.SDRAM_DQMH = dqm[1];
    bus.SDRAM_DQML = dqm[0];
    bus.SDRAM_DQ_I = dq;
    case (c)
      ACT: begin model_open[ba] = 1'b1; model_row[ba] = int'(a[ROW_W-1:0]); end
      PRE: begin
        if (a[10]) for (int b = 0; b < 4; b++) model_open[b] = 1'b0;
        else model_open[ba] = 1'b0;
      end
      LMR: cl_model = (a[6:4] == 3'd3) ? 3 : 2;
      WR: begin
        idx = idx_of(int'(ba), a);
        w = model_mem.exists(idx) ? model_mem[idx] : 16'hxxxx;
        if (!dqm[0]) w[7:0]  = dq[7:0];
        if (!dqm[1]) w[15:8] = dq[15:8];
        model_mem[idx] = w;
      end
      RD: begin
        if (dqm != 2'b11) begin
          idx = idx_of(int'(ba), a);
          exp_oe[cyc + cl_model] = ~dqm;
          exp_dq[cyc + cl_model] = model_mem[idx];
        end
      end
      default: ;
    endcase
    tick();
  endtask

  task automatic do_init();
    issue(PRE, 2'd0, 13'h400, 2'b00, 16'h0);
    nop(2);
    issue(REF, 2'd0, 13'h000, 2'b00, 16'h0);
    nop(8);
    issue(REF, 2'd0, 13'h000, 2'b00, 16'h0);
    nop(8);
    issue(LMR, 2'd0, 13'h220, 2'b00, 16'h0);
    nop(1);
  endtask

  task automatic random_ops(input int n);
    int b;
    int idx;
    logic [12:0] a;
    logic [1:0]  m;
    for (int k = 0; k < n; k++) begin
      b = int'($urandom_range(0, 3));
      a = 13'($urandom);
      a[COL_W-1:0] = COL_W'($urandom_range(0, 7));
      idx = idx_of(b, a);
      m = 2'($urandom);
      if (model_mem.exists(idx) && $urandom_range(0, 1) == 1)
        issue(RD, 2'(b), a, m, 16'h0);
      else
        issue(WR, 2'(b), a, model_mem.exists(idx) ? m : 2'b00, 16'($urandom));
      if ($urandom_range(0, 3) == 0) nop(1);
    end
  endtask

  task automatic model_reset();
    exp_oe.delete();
    exp_dq.delete();
    for (int b = 0; b < 4; b++) model_open[b] = 1'b0;
    cl_model = 2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SDRAM_nCS  = 1'b0;
    bus.SDRAM_CKE  = 1'b1;
    {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = NOP;
    bus.SDRAM_BA   = 2'd0;
    bus.SDRAM_A    = 13'h0;
    bus.SDRAM_DQML = 1'b0;
    bus.SDRAM_DQMH = 1'b0;
    bus.SDRAM_DQ_I = 16'h0;
    model_reset();

    // Reset state
    nop(2);
    check("rst_init", 32'(initialized), 32'd0);
    check("rst_mode", 32'(mode_reg), 32'd0);
    check("rst_rfsh", 32'(rfsh_count), 32'd0);
    check_flags("rst_flags", 4'b0000);
    init_n = 1'b1;
    nop(1);

    // Init sequence
    do_init();
    check("init_done", 32'(initialized), 32'd1);
    check("init_mode", 32'(mode_reg), 32'h220);
    check("init_rfsh", 32'(rfsh_count), 32'd2);
    check_flags("init_flags", 4'b0000);

    // CL2 round trip
    issue(ACT, 2'd1, 13'h003, 2'b00, 16'h0);
    nop(1);
    issue(WR, 2'd1, 13'h005, 2'b00, 16'hA55A);
    nop(1);
    issue(RD, 2'd1, 13'h005, 2'b00, 16'h0);
    nop(1);
    check("rt_data", 32'(bus.SDRAM_DQ_O), 32'hA55A);
    nop(2);

    // Byte masks
    issue(WR, 2'd1, 13'h006, 2'b00, 16'h1234);
    issue(WR, 2'd1, 13'h006, 2'b10, 16'hFFFF);
    issue(RD, 2'd1, 13'h006, 2'b00, 16'h0);
    nop(1);
    check("mask_data", 32'(bus.SDRAM_DQ_O), 32'h12FF);
    nop(2);
    issue(RD, 2'd1, 13'h006, 2'b01, 16'h0);
    nop(1);
    check("mask_oe", 32'(bus.SDRAM_DQ_OE), 32'h2);
    nop(2);

    // Randomized traffic across all banks at CL2
    for (int b = 0; b < 4; b++)
      if (!model_open[b]) issue(ACT, 2'(b), 13'($urandom), 2'b00, 16'h0);
    nop(2);
    random_ops(150);
    nop(4);
    check_flags("rand_cl2_flags", 4'b0000);

    // CL3
    issue(LMR, 2'd0, 13'h230, 2'b00, 16'h0);
    nop(2);
    issue(RD, 2'd1, 13'h005, 2'b00, 16'h0);
    nop(1);
    check("cl3_early_oe", 32'(bus.SDRAM_DQ_OE), 32'h0);
    nop(1);
    check("cl3_oe", 32'(bus.SDRAM_DQ_OE), 32'h3);
    nop(2);
    random_ops(40);
    nop(4);
    check_flags("rand_cl3_flags", 4'b0000);
    issue(LMR, 2'd0, 13'h231, 2'b00, 16'h0);
    nop(1);
    check("bad_mode_reg", 32'(mode_reg), 32'h231);
    check_flags("bad_mode_flags", 4'b0001);

    // Timing violation: READ one cycle after ACTIVE
    issue(PRE, 2'd2, 13'h000, 2'b00, 16'h0);
    nop(3);
    issue(ACT, 2'd2, 13'h005, 2'b00, 16'h0);
    issue(RD, 2'd2, 13'h001, 2'b11, 16'h0);
    check_flags("trcd_flags", 4'b0011);
    nop(2);
    // Bank violation: READ to idle bank
    issue(PRE, 2'd2, 13'h000, 2'b00, 16'h0);
    nop(3);
    issue(RD, 2'd2, 13'h001, 2'b11, 16'h0);
    check_flags("idle_rd_flags", 4'b0111);
    nop(4);

    // Reset in the middle of a CL3 read
    issue(RD, 2'd1, 13'h005, 2'b00, 16'h0);
    nop(1);
    init_n = 1'b0;
    #1;
    check("mid_rst_oe", 32'(bus.SDRAM_DQ_OE), 32'h0);
    check("mid_rst_init", 32'(initialized), 32'd0);
    check("mid_rst_mode", 32'(mode_reg), 32'd0);
    check_flags("mid_rst_flags", 4'b0000);
    model_reset();
    nop(3);
    init_n = 1'b1;
    nop(2);

    // ACTIVE before init, then refresh with a bank open
    issue(ACT, 2'd0, 13'h001, 2'b00, 16'h0);
    check("pre_init_init", 32'(initialized), 32'd0);
    check_flags("seq_flags", 4'b1000);
    do_init();
    check("reinit_done", 32'(initialized), 32'd1);
    check("reinit_rfsh", 32'(rfsh_count), 32'd2);
    check_flags("reinit_flags", 4'b1000);
    issue(ACT, 2'd1, 13'h003, 2'b00, 16'h0);
    nop(2);
    issue(REF, 2'd0, 13'h000, 2'b00, 16'h0);
    check("open_ref_rfsh", 32'(rfsh_count), 32'd3);
    check_flags("open_ref_flags", 4'b1100);
    nop(8);

    // Storage retained across reset
    issue(RD, 2'd1, 13'h005, 2'b00, 16'h0);
    issue(RD, 2'd1, 13'h006, 2'b00, 16'h0);
    nop(4);
    check_flags("sticky_flags", 4'b1100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable responder for the device end of the single-chip SDR SDRAM interface (MT48LC16M16-style command bus, 16-bit data).
- Decodes the command bus each clock and tracks init sequence, mode register and per-bank open rows.
- Serves READ/WRITE from a small internal word array, returning read data after the programmed CAS latency.
- Used on-chip as a stand-in memory for controller bring-up, and as the bench responder for controller verification; flags protocol and timing violations as sticky status.

Parameters:
ROW_W, 4, row address bits used for storage indexing (A[ROW_W-1:0] at ACTIVE)
COL_W, 5, column bits used for storage indexing (A[COL_W-1:0] at READ/WRITE)
TRCD, 2, minimum cycles from ACTIVE to READ/WRITE on the same bank
TRP, 2, minimum cycles from PRECHARGE to ACTIVE/AUTO_REFRESH
TRFC, 7, minimum cycles from AUTO_REFRESH to any non-NOP command

Ports:
clk  in  1  clock (~100MHz), all state on rising edge
init_n  in  1  asynchronous active-low reset
SDRAM_nCS  in  1  chip select, active low
SDRAM_nRAS  in  1  row strobe
SDRAM_nCAS  in  1  column strobe
SDRAM_nWE  in  1  write enable
SDRAM_CKE  in  1  clock enable; 0 = command ignored
SDRAM_BA  in  2  bank address
SDRAM_A  in  13  multiplexed address
SDRAM_DQML  in  1  low byte mask
SDRAM_DQMH  in  1  high byte mask
SDRAM_DQ_I  in  16  data from controller
SDRAM_DQ_O  out  16  data to controller
SDRAM_DQ_OE  out  2  per-byte output enable {high, low}
initialized  out  1  init sequence complete
mode_reg  out  13  last LOAD_MODE value
rfsh_count  out  16  AUTO_REFRESH count, wraps at 0xFFFF->0
err_seq  out  1  sticky: ACTIVE/READ/WRITE before initialized
err_bank  out  1  sticky: READ/WRITE to idle bank, ACTIVE to open bank, or REFRESH with any bank open
err_timing  out  1  sticky: TRCD/TRP/TRFC violation
err_mode  out  1  sticky: LOAD_MODE with BL!=000 or CL not 2/3

Behaviour:
- Reset (init_n=0, async): all outputs 0. Banks idle, timers saturated (no violation pending), read pipeline empty, mode_reg=0. Storage is not cleared.
- Command sampled only when CKE=1 and nCS=0. Encoding {nRAS,nCAS,nWE}: 111 NOP, 110 BST (ignored), 101 READ, 100 WRITE, 011 ACTIVE, 010 PRECHARGE, 001 AUTO_REFRESH, 000 LOAD_MODE.
- Init tracker states: WAIT_PRE -> WAIT_RF1 -> WAIT_RF2 -> WAIT_MODE -> READY.
  - WAIT_PRE: PRECHARGE with A10=1 advances.
  - WAIT_RF1, WAIT_RF2: each AUTO_REFRESH advances one state.
  - WAIT_MODE: LOAD_MODE advances to READY.
  - Any other non-NOP command in these states sets err_seq; the state is unchanged.
  - Repeated sequences after READY are legal.
  - initialized=1 in READY.
- LOAD_MODE: mode_reg<=A. CL=A[6:4]. Values other than 2/3 set err_mode, and CL=2 is used. BL=A[2:0]!=0 sets err_mode; access is still single-word.
- ACTIVE: the bank must be idle, else err_bank, and the row is overwritten. Stores row A[ROW_W-1:0] and restarts that bank's tRCD timer.
- PRECHARGE:
  - A10=1 closes all banks; otherwise closes bank BA.
  - Starts the TRP timer.
  - ACTIVE or AUTO_REFRESH before TRP cycles sets err_timing.
- AUTO_REFRESH: any bank open sets err_bank. rfsh_count+1, TRFC timer starts. Any non-NOP command before TRFC cycles sets err_timing.
- Storage word index is {BA, row, A[COL_W-1:0]}, depth 2^(2+ROW_W+COL_W). Upper address bits are ignored (aliasing). Bank idle at READ/WRITE: err_bank, and row 0 is used.
- WRITE at edge t: DQ_I captured at edge t. Byte written only if its DQM=0. Write visible to a READ at edge t+1.
- READ at edge t:
  - The word and inverted DQM pair enter a CL-deep pipeline.
  - DQ_O and DQ_OE are registered and valid after edge t+CL-1, so the controller samples at edge t+CL.
  - DQ_OE is high for exactly one cycle, per byte = ~DQM sampled at READ.
  - DQ_O=0 when DQ_OE=00.
- Back-to-back READs every cycle are supported, one pipeline slot per cycle. READ issued 1 cycle before a WRITE: both happen; no bus-conflict check.
- A READ and a TRCD/TRP violation in the same command both act: err_timing is set and the access completes.
- Simultaneous flags: all applicable error bits set in the same cycle.
- Reset mid-read: pipeline flushed, DQ_OE=0 after init_n falls, asynchronously.

Test Plan:
- Init sequence: PRECHARGE A10=1, REFRESH, wait 8, REFRESH, wait 8, LOAD_MODE A=0x220 -> initialized=1, mode_reg=0x220, all err=0, rfsh_count=2.
- CL2 round trip: ACTIVE BA=1 row 3; +2 WRITE col 5 DQ=0xA55A DQM=00; +2 READ col 5 at edge t -> DQ_OE=11 and DQ_O=0xA55A sampled at edge t+2 only.
- Byte mask: write 0x1234 then WRITE 0xFFFF with DQMH=1 -> readback 0x12FF. READ with DQML=1 -> DQ_OE=10.
- CL3: LOAD_MODE A=0x230 -> read data at edge t+3, not t+2. LOAD_MODE A=0x231 -> err_mode=1.
- Violations:
  - READ to idle bank 2 -> err_bank.
  - READ 1 cycle after ACTIVE -> err_timing.
  - REFRESH with bank open -> err_bank.
  - ACTIVE before init -> err_seq.
  - All flags stay set until reset.
- Reset mid-read: READ issued, init_n low before data -> DQ_OE=0, initialized=0, errors 0. After release, storage contents are retained on re-init and readback.
